// File: rtl/ft64_align_pkg.sv
// Shared constants and the FT64 head-byte length rule for the instruction aligner
// and fetch-side predictors.
package ft64_align_pkg;

   localparam int unsigned FW_BYTES      = 8;
   localparam int unsigned MAX_INS_BYTES = 7;
   localparam int unsigned INS_W         = 48;

   localparam logic [2:0] LEN_2 = 3'd2;
   localparam logic [2:0] LEN_4 = 3'd4;
   localparam logic [2:0] LEN_6 = 3'd6;

   // Same value as `CMPRSSD in FT64_defines.vh.
   localparam logic [5:0] CMPRSSD = 6'h3F;

   function automatic logic [2:0] base_len(input logic [7:0] b0, input logic dci_en);
      if (dci_en && (b0[5:0] == CMPRSSD)) return LEN_2;
      if (b0[7])                          return LEN_2;
      if (b0[6])                          return LEN_6;
      return LEN_4;
   endfunction

endpackage

// File: rtl/ft64_head_len.sv
// Combinational FT64 instruction length decoder: head byte and predication mode in,
// byte length (2..7) out.
module ft64_head_len
   import ft64_align_pkg::*;
#(
   parameter bit SUPPORT_DCI = 1'b1
) (
   input  logic [7:0] b0_i,
   input  logic       pred_on_i,
   output logic [2:0] len_o
);

   always_comb begin
      len_o = base_len(b0_i, SUPPORT_DCI) | {2'b00, pred_on_i};
   end

endmodule

// File: rtl/ft64_ins_aligner.sv
// FT64 instruction aligner: buffers 8-byte fetch words as a byte FIFO and presents
// one left-justified instruction per cycle, with length and PC, to decode.
module ft64_ins_aligner
   import ft64_align_pkg::*;
#(
   parameter int unsigned BUF_BYTES   = 16,
   parameter int unsigned SUPPORT_DCI = 1,
   parameter int unsigned AW          = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          pred_on_i,
   input  logic                          flush_i,
   input  logic [AW-1:0]                 flush_pc_i,
   input  logic                          fw_valid_i,
   output logic                          fw_ready_o,
   input  logic [63:0]                   fw_data_i,
   output logic                          ins_valid_o,
   input  logic                          ins_ready_i,
   output logic [INS_W-1:0]              ins_o,
   output logic [2:0]                    len_o,
   output logic [AW-1:0]                 pc_o,
   output logic [$clog2(BUF_BYTES):0]    count_o
);

   localparam int unsigned CW  = $clog2(BUF_BYTES) + 1;
   localparam int unsigned BW  = 8 * BUF_BYTES;
   localparam int unsigned FWW = 8 * FW_BYTES;

   logic [BW-1:0] r_buf;
   logic [CW-1:0] r_count;
   logic [AW-1:0] r_pc;

   logic [BW-1:0] w_shifted;
   logic [BW-1:0] w_app_mask;
   logic [BW-1:0] w_app_data;
   logic [BW-1:0] w_buf_nxt;
   logic [CW-1:0] w_wr_base;
   logic [CW-1:0] w_count_nxt;
   logic [CW-1:0] w_len_cw;
   logic [2:0]    w_len;
   logic          w_push;
   logic          w_pop;

   ft64_head_len #(
      .SUPPORT_DCI (SUPPORT_DCI != 0)
   ) u_head_len (
      .b0_i      (r_buf[7:0]),
      .pred_on_i (pred_on_i),
      .len_o     (w_len)
   );

   assign w_len_cw    = CW'(w_len);
   assign ins_valid_o = (r_count >= w_len_cw) && !flush_i;
   assign fw_ready_o  = (r_count <= CW'(BUF_BYTES - FW_BYTES)) && !flush_i;
   assign w_push      = fw_valid_i && fw_ready_o;
   assign w_pop       = ins_valid_o && ins_ready_i;

   assign ins_o   = r_buf[INS_W-1:0];
   assign len_o   = w_len;
   assign pc_o    = r_pc;
   assign count_o = r_count;

   // Pop shifts first; the pushed word then lands right above the surviving bytes.
   always_comb begin
      w_shifted   = w_pop ? (r_buf >> {w_len, 3'b000}) : r_buf;
      w_wr_base   = w_pop ? (r_count - w_len_cw) : r_count;
      w_app_mask  = {{(BW-FWW){1'b0}}, {FWW{1'b1}}} << {w_wr_base, 3'b000};
      w_app_data  = {{(BW-FWW){1'b0}}, fw_data_i} << {w_wr_base, 3'b000};
      w_buf_nxt   = w_push ? ((w_shifted & ~w_app_mask) | w_app_data) : w_shifted;
      w_count_nxt = w_wr_base + (w_push ? CW'(FW_BYTES) : '0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_buf   <= '0;
         r_count <= '0;
         r_pc    <= '0;
      end else if (flush_i) begin
         r_buf   <= '0;
         r_count <= '0;
         r_pc    <= flush_pc_i;
      end else begin
         r_buf   <= w_buf_nxt;
         r_count <= w_count_nxt;
         if (w_pop) r_pc <= r_pc + AW'(w_len);
      end
   end

endmodule

// File: tb/tb_ft64_ins_aligner.sv
// Directed self-checking bench for ft64_ins_aligner; a second instance without the
// compressed-opcode rule is used for the DCI comparison.
module tb_ft64_ins_aligner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pred_on;
   logic        flush;
   logic [31:0] flush_pc;
   logic        fw_valid;
   logic [63:0] fw_data;
   logic        ins_ready;

   logic        fw_ready, ins_valid;
   logic [47:0] ins;
   logic [2:0]  len;
   logic [31:0] pc;
   logic [4:0]  count;

   logic        nd_fw_ready, nd_ins_valid;
   logic [47:0] nd_ins;
   logic [2:0]  nd_len;
   logic [31:0] nd_pc;
   logic [4:0]  nd_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ft64_ins_aligner #(.BUF_BYTES(16), .SUPPORT_DCI(1), .AW(32)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .pred_on_i(pred_on), .flush_i(flush),
      .flush_pc_i(flush_pc), .fw_valid_i(fw_valid), .fw_ready_o(fw_ready),
      .fw_data_i(fw_data), .ins_valid_o(ins_valid), .ins_ready_i(ins_ready),
      .ins_o(ins), .len_o(len), .pc_o(pc), .count_o(count)
   );

   ft64_ins_aligner #(.BUF_BYTES(16), .SUPPORT_DCI(0), .AW(32)) u_nodci (
      .clk_i(clk), .rst_ni(rst_n), .pred_on_i(pred_on), .flush_i(flush),
      .flush_pc_i(flush_pc), .fw_valid_i(fw_valid), .fw_ready_o(nd_fw_ready),
      .fw_data_i(fw_data), .ins_valid_o(nd_ins_valid), .ins_ready_i(ins_ready),
      .ins_o(nd_ins), .len_o(nd_len), .pc_o(nd_pc), .count_o(nd_count)
   );

   task automatic do_flush(input logic [31:0] fpc);
      @(negedge clk);
      flush = 1'b1; flush_pc = fpc; fw_valid = 1'b0; ins_ready = 1'b0;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pred_on = 1'b0; flush = 1'b0; flush_pc = '0;
      fw_valid = 1'b0; fw_data = '0; ins_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
      n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", pc); end
      n_cmp++; if (ins_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ins_valid); end
      n_cmp++; if (fw_ready !== 1'b1) begin n_bad++; $display("FAIL reset_fw_ready: got %b want 1", fw_ready); end
      n_cmp++; if (ins !== 48'h0) begin n_bad++; $display("FAIL reset_ins: got %h want 0", ins); end
      n_cmp++; if (len !== 3'd4) begin n_bad++; $display("FAIL reset_len: got %0d want 4", len); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      @(negedge clk);
      pred_on = 1'b0; ins_ready = 1'b0; fw_valid = 1'b1; fw_data = 64'h26252423_224011C0;
      #1;
      n_cmp++; if (fw_ready !== 1'b1) begin n_bad++; $display("FAIL str_fw_ready0: got %b want 1", fw_ready); end
      @(negedge clk);
      fw_data = 64'h43424140_33323100;
      #1;
      n_cmp++; if (count !== 5'd8) begin n_bad++; $display("FAIL str_count8: got %0d want 8", count); end
      @(negedge clk);
      fw_valid = 1'b0; ins_ready = 1'b1;
      #1;
      n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL str_count16: got %0d want 16", count); end
      n_cmp++; if (fw_ready !== 1'b0) begin n_bad++; $display("FAIL str_full: got %b want 0", fw_ready); end
      n_cmp++; if (ins_valid !== 1'b1 || len !== 3'd2 || pc !== 32'd0 || ins !== 48'h2423224011C0) begin
         n_bad++; $display("FAIL str_ins0: got v=%b len=%0d pc=%h ins=%h want v=1 len=2 pc=0 ins=2423224011c0", ins_valid, len, pc, ins); end
      @(negedge clk); #1;
      n_cmp++; if (ins_valid !== 1'b1 || len !== 3'd6 || pc !== 32'd2 || ins !== 48'h262524232240 || count !== 5'd14) begin
         n_bad++; $display("FAIL str_ins1: got v=%b len=%0d pc=%h ins=%h cnt=%0d want v=1 len=6 pc=2 ins=262524232240 cnt=14", ins_valid, len, pc, ins, count); end
      @(negedge clk); #1;
      n_cmp++; if (ins_valid !== 1'b1 || len !== 3'd4 || pc !== 32'd8 || ins !== 48'h414033323100 || count !== 5'd8) begin
         n_bad++; $display("FAIL str_ins2: got v=%b len=%0d pc=%h ins=%h cnt=%0d want v=1 len=4 pc=8 ins=414033323100 cnt=8", ins_valid, len, pc, ins, count); end
      @(negedge clk); #1;
      n_cmp++; if (ins_valid !== 1'b0 || len !== 3'd6 || pc !== 32'd12 || count !== 5'd4) begin
         n_bad++; $display("FAIL str_leftover: got v=%b len=%0d pc=%h cnt=%0d want v=0 len=6 pc=c cnt=4", ins_valid, len, pc, count); end
      ins_ready = 1'b0;
   endtask

   task automatic test_pred();
      do_flush(32'h0);
      pred_on = 1'b1; fw_valid = 1'b1; fw_data = 64'h07060504_400201C0; ins_ready = 1'b1;
      #1;
      n_cmp++; if (ins_valid !== 1'b0 || count !== 5'd0) begin n_bad++; $display("FAIL pred_empty: got v=%b cnt=%0d want v=0 cnt=0", ins_valid, count); end
      @(negedge clk);
      fw_data = 64'hC00E0D0C_0B000908;
      #1;
      n_cmp++; if (ins_valid !== 1'b1 || len !== 3'd3 || pc !== 32'd0 || ins !== 48'h0504400201C0) begin
         n_bad++; $display("FAIL pred_ins0: got v=%b len=%0d pc=%h ins=%h want v=1 len=3 pc=0 ins=0504400201c0", ins_valid, len, pc, ins); end
      @(negedge clk);
      fw_valid = 1'b0;
      #1;
      n_cmp++; if (count !== 5'd13 || len !== 3'd7 || pc !== 32'd3 || ins !== 48'h080706050440) begin
         n_bad++; $display("FAIL pred_ins1: got cnt=%0d len=%0d pc=%h ins=%h want cnt=13 len=7 pc=3 ins=080706050440", count, len, pc, ins); end
      @(negedge clk); #1;
      n_cmp++; if (count !== 5'd6 || len !== 3'd5 || pc !== 32'd10 || ins !== 48'hC00E0D0C0B00) begin
         n_bad++; $display("FAIL pred_ins2: got cnt=%0d len=%0d pc=%h ins=%h want cnt=6 len=5 pc=a ins=c00e0d0c0b00", count, len, pc, ins); end
      @(negedge clk);
      ins_ready = 1'b0;
      #1;
      n_cmp++; if (count !== 5'd1 || pc !== 32'd15 || ins_valid !== 1'b0 || len !== 3'd3) begin
         n_bad++; $display("FAIL pred_partial: got cnt=%0d pc=%h v=%b len=%0d want cnt=1 pc=f v=0 len=3", count, pc, ins_valid, len); end
      pred_on = 1'b0;
      #1;
      n_cmp++; if (len !== 3'd2 || ins_valid !== 1'b0) begin n_bad++; $display("FAIL pred_comb: got len=%0d v=%b want len=2 v=0", len, ins_valid); end
   endtask

   task automatic test_straddle();
      do_flush(32'h100);
      pred_on = 1'b0; ins_ready = 1'b1; fw_valid = 1'b1; fw_data = 64'h63626140_03020100;
      #1;
      n_cmp++; if (ins_valid !== 1'b0) begin n_bad++; $display("FAIL strad_empty: got %b want 0", ins_valid); end
      @(negedge clk);
      fw_valid = 1'b0;
      #1;
      n_cmp++; if (ins_valid !== 1'b1 || len !== 3'd4 || pc !== 32'h100 || ins !== 48'h614003020100) begin
         n_bad++; $display("FAIL strad_first: got v=%b len=%0d pc=%h ins=%h want v=1 len=4 pc=100 ins=614003020100", ins_valid, len, pc, ins); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_cmp++; if (ins_valid !== 1'b0 || count !== 5'd4 || len !== 3'd6) begin
            n_bad++; $display("FAIL strad_wait%0d: got v=%b cnt=%0d len=%0d want v=0 cnt=4 len=6", i, ins_valid, count, len); end
      end
      @(negedge clk);
      fw_valid = 1'b1; fw_data = 64'h75747372_71C06564;
      #1;
      n_cmp++; if (ins_valid !== 1'b0) begin n_bad++; $display("FAIL strad_pushcyc: got %b want 0", ins_valid); end
      @(negedge clk);
      fw_valid = 1'b0;
      #1;
      n_cmp++; if (ins_valid !== 1'b1 || len !== 3'd6 || pc !== 32'h104 || ins !== 48'h656463626140 || count !== 5'd12) begin
         n_bad++; $display("FAIL strad_ins: got v=%b len=%0d pc=%h ins=%h cnt=%0d want v=1 len=6 pc=104 ins=656463626140 cnt=12", ins_valid, len, pc, ins, count); end
      @(negedge clk); #1;
      n_cmp++; if (len !== 3'd2 || pc !== 32'h10A || count !== 5'd6) begin
         n_bad++; $display("FAIL strad_next: got len=%0d pc=%h cnt=%0d want len=2 pc=10a cnt=6", len, pc, count); end
      ins_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      do_flush(32'h0);
      ins_ready = 1'b0; fw_valid = 1'b1; fw_data = 64'h13121100_03020100;
      #1;
      n_cmp++; if (fw_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready0: got %b want 1", fw_ready); end
      @(negedge clk);
      fw_data = 64'h33323100_23222100;
      #1;
      n_cmp++; if (fw_ready !== 1'b1 || count !== 5'd8) begin n_bad++; $display("FAIL bp_ready8: got rdy=%b cnt=%0d want rdy=1 cnt=8", fw_ready, count); end
      @(negedge clk);
      fw_data = 64'hDEADBEEF_DEADBEEF;
      #1;
      n_cmp++; if (fw_ready !== 1'b0 || count !== 5'd16) begin n_bad++; $display("FAIL bp_full: got rdy=%b cnt=%0d want rdy=0 cnt=16", fw_ready, count); end
      @(negedge clk);
      fw_valid = 1'b0;
      #1;
      n_cmp++; if (count !== 5'd16 || ins !== 48'h110003020100 || pc !== 32'd0) begin
         n_bad++; $display("FAIL bp_noloss: got cnt=%0d ins=%h pc=%h want cnt=16 ins=110003020100 pc=0", count, ins, pc); end
      ins_ready = 1'b1;
      @(negedge clk); #1;
      n_cmp++; if (count !== 5'd12 || fw_ready !== 1'b0 || pc !== 32'd4 || ins !== 48'h210013121100) begin
         n_bad++; $display("FAIL bp_drain1: got cnt=%0d rdy=%b pc=%h ins=%h want cnt=12 rdy=0 pc=4 ins=210013121100", count, fw_ready, pc, ins); end
      @(negedge clk); #1;
      n_cmp++; if (count !== 5'd8 || fw_ready !== 1'b1 || ins !== 48'h310023222100) begin
         n_bad++; $display("FAIL bp_drain2: got cnt=%0d rdy=%b ins=%h want cnt=8 rdy=1 ins=310023222100", count, fw_ready, ins); end
      @(negedge clk); #1;
      n_cmp++; if (count !== 5'd4 || ins[31:0] !== 32'h33323100) begin
         n_bad++; $display("FAIL bp_drain3: got cnt=%0d ins=%h want cnt=4 ins[31:0]=33323100", count, ins[31:0]); end
      @(negedge clk); #1;
      n_cmp++; if (count !== 5'd0 || ins_valid !== 1'b0 || fw_ready !== 1'b1) begin
         n_bad++; $display("FAIL bp_empty: got cnt=%0d v=%b rdy=%b want cnt=0 v=0 rdy=1", count, ins_valid, fw_ready); end
      ins_ready = 1'b0;
   endtask

   task automatic test_flush();
      do_flush(32'h0);
      fw_valid = 1'b1; fw_data = 64'h07060504_03020100;
      @(negedge clk);
      flush = 1'b1; flush_pc = 32'h0000_1000; fw_data = 64'hAAAAAAAA_AAAAAAAA; ins_ready = 1'b1;
      #1;
      n_cmp++; if (ins_valid !== 1'b0 || fw_ready !== 1'b0) begin
         n_bad++; $display("FAIL flush_gate: got v=%b rdy=%b want v=0 rdy=0", ins_valid, fw_ready); end
      @(negedge clk);
      flush = 1'b0; fw_valid = 1'b0; ins_ready = 1'b0;
      #1;
      n_cmp++; if (count !== 5'd0 || pc !== 32'h1000 || ins_valid !== 1'b0 || fw_ready !== 1'b1) begin
         n_bad++; $display("FAIL flush_state: got cnt=%0d pc=%h v=%b rdy=%b want cnt=0 pc=1000 v=0 rdy=1", count, pc, ins_valid, fw_ready); end
   endtask

   task automatic test_dci();
      do_flush(32'h0);
      pred_on = 1'b0; fw_valid = 1'b1; fw_data = 64'h0000_0000_0000_003F;
      @(negedge clk);
      fw_valid = 1'b0;
      #1;
      n_cmp++; if (len !== 3'd2 || ins_valid !== 1'b1) begin n_bad++; $display("FAIL dci_on: got len=%0d v=%b want len=2 v=1", len, ins_valid); end
      n_cmp++; if (nd_len !== 3'd4 || nd_ins_valid !== 1'b1 || nd_count !== 5'd8 || nd_pc !== 32'd0 || nd_ins[7:0] !== 8'h3F || nd_fw_ready !== 1'b1) begin
         n_bad++; $display("FAIL dci_off: got len=%0d v=%b cnt=%0d pc=%h b0=%h rdy=%b want len=4 v=1 cnt=8 pc=0 b0=3f rdy=1", nd_len, nd_ins_valid, nd_count, nd_pc, nd_ins[7:0], nd_fw_ready); end
      pred_on = 1'b1;
      #1;
      n_cmp++; if (len !== 3'd3 || nd_len !== 3'd5) begin n_bad++; $display("FAIL dci_pred: got len=%0d/%0d want 3/5", len, nd_len); end
      pred_on = 1'b0;
   endtask

   task automatic test_pc_wrap();
      do_flush(32'hFFFF_FFFE);
      fw_valid = 1'b1; fw_data = 64'h0000_0000_0000_00C0;
      @(negedge clk);
      fw_valid = 1'b0; ins_ready = 1'b1;
      #1;
      n_cmp++; if (pc !== 32'hFFFF_FFFE || len !== 3'd2) begin n_bad++; $display("FAIL wrap_pre: got pc=%h len=%0d want pc=fffffffe len=2", pc, len); end
      @(negedge clk);
      ins_ready = 1'b0;
      #1;
      n_cmp++; if (pc !== 32'd0 || len !== 3'd4 || count !== 5'd6) begin
         n_bad++; $display("FAIL wrap_post: got pc=%h len=%0d cnt=%0d want pc=0 len=4 cnt=6", pc, len, count); end
   endtask

   task automatic test_async_reset();
      do_flush(32'h40);
      fw_valid = 1'b1; fw_data = 64'h1111_2222_3333_4444;
      @(negedge clk);
      fw_valid = 1'b0;
      #1;
      n_cmp++; if (count !== 5'd8 || pc !== 32'h40) begin n_bad++; $display("FAIL arst_pre: got cnt=%0d pc=%h want cnt=8 pc=40", count, pc); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (count !== 5'd0 || pc !== 32'd0 || ins_valid !== 1'b0 || ins !== 48'h0) begin
         n_bad++; $display("FAIL arst_async: got cnt=%0d pc=%h v=%b ins=%h want all 0", count, pc, ins_valid, ins); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_pred();
      test_straddle();
      test_backpressure();
      test_flush();
      test_dci();
      test_pc_wrap();
      test_async_reset();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
